// File: rtl/bkm_data_step_driver.sv
// Stimulus driver for the bkm_data_step DUT/checker pair: issues stream vectors
// one per cycle and delays each one so the checker sees it with the DUT result.
module bkm_data_step_driver #(
  parameter int unsigned W     = 64,
  parameter int unsigned LOG2N = 6,
  parameter int unsigned LAT   = 1,
  parameter int unsigned CW    = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             srst,
  input  logic             start,
  input  logic             vec_vld,
  output logic             vec_rdy,
  input  logic             vec_last,
  input  logic             vec_mode,
  input  logic [1:0]       vec_format,
  input  logic [LOG2N-1:0] vec_n,
  input  logic [1:0]       vec_d_x_n,
  input  logic [1:0]       vec_d_y_n,
  input  logic [W-1:0]     vec_X_n,
  input  logic [W-1:0]     vec_Y_n,
  input  logic [W-1:0]     vec_X_np1,
  input  logic [W-1:0]     vec_Y_np1,
  output logic             dut_vld,
  output logic             dut_mode,
  output logic [1:0]       dut_format,
  output logic [LOG2N-1:0] dut_n,
  output logic [1:0]       dut_d_x_n,
  output logic [1:0]       dut_d_y_n,
  output logic [W-1:0]     dut_X_n,
  output logic [W-1:0]     dut_Y_n,
  output logic             chk_enable,
  output logic             chk_mode,
  output logic [1:0]       chk_format,
  output logic [LOG2N-1:0] chk_n,
  output logic [1:0]       chk_d_x_n,
  output logic [1:0]       chk_d_y_n,
  output logic [W-1:0]     chk_X_n,
  output logic [W-1:0]     chk_Y_n,
  output logic [W-1:0]     chk_X_np1,
  output logic [W-1:0]     chk_Y_np1,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    cnt_issued,
  output logic [CW-1:0]    cnt_checked
);

  typedef struct packed {
    logic             mode;
    logic [1:0]       format;
    logic [LOG2N-1:0] n;
    logic [1:0]       d_x_n;
    logic [1:0]       d_y_n;
    logic [W-1:0]     X_n;
    logic [W-1:0]     Y_n;
    logic [W-1:0]     X_np1;
    logic [W-1:0]     Y_np1;
  } vec_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  vec_t              cap_q, cap_d;
  logic              cap_vld_q, cap_vld_d;
  vec_t [LAT-1:0]    stg_q, stg_d;
  logic [LAT-1:0]    stg_vld_q, stg_vld_d;
  logic [CW-1:0]     iss_q, iss_d;
  logic [CW-1:0]     chk_q, chk_d;

  vec_t vin;
  logic accept;
  logic clear;
  logic pipe_busy;

  always_comb begin
    vin       = {vec_mode, vec_format, vec_n, vec_d_x_n, vec_d_y_n,
                 vec_X_n, vec_Y_n, vec_X_np1, vec_Y_np1};
    accept    = vec_vld && (state_q == S_RUN);
    clear     = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    cap_d     = accept ? vin : cap_q;
    cap_vld_d = accept;

    // The capture register doubles as the DUT input register, so the LAT
    // delay stages sit behind it: chk_enable trails dut_vld by exactly LAT.
    stg_d        = stg_q;
    stg_vld_d    = stg_vld_q;
    stg_d[0]     = cap_q;
    stg_vld_d[0] = cap_vld_q;
    for (int unsigned i = 1; i < LAT; i++) begin
      stg_d[i]     = stg_q[i-1];
      stg_vld_d[i] = stg_vld_q[i-1];
    end

    // Empty after this edge: only the final stage may still be presenting.
    pipe_busy = cap_vld_q;
    for (int unsigned i = 0; i + 1 < LAT; i++) begin
      pipe_busy = pipe_busy | stg_vld_q[i];
    end

    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN:          if (accept && vec_last) state_d = S_DRAIN;
      S_DRAIN:        if (!pipe_busy) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase

    iss_d = iss_q;
    chk_d = chk_q;
    if (clear) begin
      iss_d = '0;
      chk_d = '0;
    end else begin
      if (accept && (iss_q != '1)) iss_d = iss_q + CW'(1);
      if (stg_vld_q[LAT-1] && (chk_q != '1)) chk_d = chk_q + CW'(1);
    end

    if (srst) begin
      state_d   = S_IDLE;
      cap_d     = '0;
      cap_vld_d = 1'b0;
      stg_d     = '0;
      stg_vld_d = '0;
      iss_d     = '0;
      chk_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q   <= S_IDLE;
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
      stg_q     <= '0;
      stg_vld_q <= '0;
      iss_q     <= '0;
      chk_q     <= '0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      cap_vld_q <= cap_vld_d;
      stg_q     <= stg_d;
      stg_vld_q <= stg_vld_d;
      iss_q     <= iss_d;
      chk_q     <= chk_d;
    end
  end

  assign vec_rdy     = (state_q == S_RUN);
  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign cnt_issued  = iss_q;
  assign cnt_checked = chk_q;

  assign dut_vld    = cap_vld_q;
  assign dut_mode   = cap_q.mode;
  assign dut_format = cap_q.format;
  assign dut_n      = cap_q.n;
  assign dut_d_x_n  = cap_q.d_x_n;
  assign dut_d_y_n  = cap_q.d_y_n;
  assign dut_X_n    = cap_q.X_n;
  assign dut_Y_n    = cap_q.Y_n;

  assign chk_enable = stg_vld_q[LAT-1];
  assign chk_mode   = stg_q[LAT-1].mode;
  assign chk_format = stg_q[LAT-1].format;
  assign chk_n      = stg_q[LAT-1].n;
  assign chk_d_x_n  = stg_q[LAT-1].d_x_n;
  assign chk_d_y_n  = stg_q[LAT-1].d_y_n;
  assign chk_X_n    = stg_q[LAT-1].X_n;
  assign chk_Y_n    = stg_q[LAT-1].Y_n;
  assign chk_X_np1  = stg_q[LAT-1].X_np1;
  assign chk_Y_np1  = stg_q[LAT-1].Y_np1;

endmodule

// File: tb/tb_bkm_data_step_driver.sv
// Bench for bkm_data_step_driver: three LAT/CW variants share one stimulus
// stream and are compared every cycle against a vector-history model.
`timescale 1ns/1ps
module tb_bkm_data_step_driver;
  localparam int W     = 64;
  localparam int LOG2N = 6;
  localparam int NI    = 3;

  typedef struct packed {
    logic             mode;
    logic [1:0]       format;
    logic [LOG2N-1:0] n;
    logic [1:0]       dx;
    logic [1:0]       dy;
    logic [W-1:0]     xn;
    logic [W-1:0]     yn;
    logic [W-1:0]     xnp1;
    logic [W-1:0]     ynp1;
  } vec_t;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 3;
  endfunction
  function automatic int cmax_of(input int i);
    return (i == 2) ? 15 : 65535;
  endfunction
  function automatic vec_t dut_part(input vec_t v);
    vec_t r = v;
    r.xnp1 = '0;
    r.ynp1 = '0;
    return r;
  endfunction

  logic clk = 1'b0;
  logic arst, srst, start, vec_vld, vec_last;
  vec_t vin;

  logic        vrdy [NI];
  logic        dvld [NI];
  logic        cen  [NI];
  logic        bsy  [NI];
  logic        dne  [NI];
  vec_t        dutv [NI];
  vec_t        chkv [NI];
  logic [15:0] ciss [NI];
  logic [15:0] cchk [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int unsigned CWG = (gi == 2) ? 4 : 16;
    localparam int unsigned LG  = (gi == 0) ? 1 : (gi == 1) ? 4 : 3;
    logic g_rdy, g_dvld, g_dmode, g_cen, g_cmode, g_busy, g_done;
    logic [1:0] g_dfmt, g_ddx, g_ddy, g_cfmt, g_cdx, g_cdy;
    logic [LOG2N-1:0] g_dn, g_cn;
    logic [W-1:0] g_dxn, g_dyn, g_cxn, g_cyn, g_cxp, g_cyp;
    logic [CWG-1:0] g_iss, g_chk;

    bkm_data_step_driver #(.W(W), .LOG2N(LOG2N), .LAT(LG), .CW(CWG)) u_dut (
      .clk(clk), .arst(arst), .srst(srst), .start(start),
      .vec_vld(vec_vld), .vec_rdy(g_rdy), .vec_last(vec_last),
      .vec_mode(vin.mode), .vec_format(vin.format), .vec_n(vin.n),
      .vec_d_x_n(vin.dx), .vec_d_y_n(vin.dy), .vec_X_n(vin.xn), .vec_Y_n(vin.yn),
      .vec_X_np1(vin.xnp1), .vec_Y_np1(vin.ynp1),
      .dut_vld(g_dvld), .dut_mode(g_dmode), .dut_format(g_dfmt), .dut_n(g_dn),
      .dut_d_x_n(g_ddx), .dut_d_y_n(g_ddy), .dut_X_n(g_dxn), .dut_Y_n(g_dyn),
      .chk_enable(g_cen), .chk_mode(g_cmode), .chk_format(g_cfmt), .chk_n(g_cn),
      .chk_d_x_n(g_cdx), .chk_d_y_n(g_cdy), .chk_X_n(g_cxn), .chk_Y_n(g_cyn),
      .chk_X_np1(g_cxp), .chk_Y_np1(g_cyp),
      .busy(g_busy), .done(g_done), .cnt_issued(g_iss), .cnt_checked(g_chk)
    );

    assign vrdy[gi] = g_rdy;
    assign dvld[gi] = g_dvld;
    assign cen[gi]  = g_cen;
    assign bsy[gi]  = g_busy;
    assign dne[gi]  = g_done;
    assign dutv[gi] = {g_dmode, g_dfmt, g_dn, g_ddx, g_ddy, g_dxn, g_dyn, {(2*W){1'b0}}};
    assign chkv[gi] = {g_cmode, g_cfmt, g_cn, g_cdx, g_cdy, g_cxn, g_cyn, g_cxp, g_cyp};
    assign ciss[gi] = 16'(g_iss);
    assign cchk[gi] = 16'(g_chk);
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: remembers every accepted vector by cycle; outputs follow from history.
  vec_t ring_d [NI][16];
  logic ring_v [NI][16];
  logic m_armed [NI], m_last [NI], m_done [NI];
  int   m_lcyc [NI];
  int   cyc = 0;
  logic e_rdy [NI], e_dvld [NI], e_cen [NI], e_busy [NI], e_done [NI];
  vec_t e_dut [NI], e_chk [NI];
  int   e_iss [NI], e_cchk [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < 16; j++) begin
        ring_v[i][j] = 1'b0;
        ring_d[i][j] = '0;
      end
      m_armed[i] = 0; m_last[i] = 0; m_done[i] = 0; m_lcyc[i] = 0;
      e_rdy[i] = 0; e_dvld[i] = 0; e_cen[i] = 0; e_busy[i] = 0; e_done[i] = 0;
      e_dut[i] = '0; e_chk[i] = '0; e_iss[i] = 0; e_cchk[i] = 0;
    end
  endtask

  always @(posedge clk or negedge arst) begin
    if (!arst || srst) begin
      model_reset();
    end else begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
        logic acc;
        int   lat, old;
        lat = lat_of(i);
        acc = vec_vld && e_rdy[i];
        if (e_cen[i] && e_cchk[i] < cmax_of(i)) e_cchk[i]++;
        if (start && (!m_armed[i] || m_done[i])) begin
          m_armed[i] = 1; m_last[i] = 0; e_iss[i] = 0; e_cchk[i] = 0;
        end
        e_dvld[i] = acc;
        if (acc) begin
          e_dut[i] = vin;
          if (e_iss[i] < cmax_of(i)) e_iss[i]++;
          if (vec_last) begin m_last[i] = 1; m_lcyc[i] = cyc; end
        end
        ring_v[i][cyc % 16] = acc;
        if (acc) ring_d[i][cyc % 16] = vin;
        old = (cyc + 16 - lat) % 16;
        e_cen[i] = ring_v[i][old];
        if (e_cen[i]) e_chk[i] = ring_d[i][old];
        m_done[i] = m_armed[i] && m_last[i] && (cyc >= m_lcyc[i] + lat + 1);
        e_rdy[i]  = m_armed[i] && !m_last[i];
        e_busy[i] = m_armed[i] && !m_done[i];
        e_done[i] = m_done[i];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d.vec_rdy", i),     300'(vrdy[i]), 300'(e_rdy[i]));
      check($sformatf("u%0d.dut_vld", i),     300'(dvld[i]), 300'(e_dvld[i]));
      check($sformatf("u%0d.dut_fields", i),  300'(dutv[i]), 300'(dut_part(e_dut[i])));
      check($sformatf("u%0d.chk_enable", i),  300'(cen[i]),  300'(e_cen[i]));
      check($sformatf("u%0d.chk_fields", i),  300'(chkv[i]), 300'(e_chk[i]));
      check($sformatf("u%0d.busy", i),        300'(bsy[i]),  300'(e_busy[i]));
      check($sformatf("u%0d.done", i),        300'(dne[i]),  300'(e_done[i]));
      check($sformatf("u%0d.cnt_issued", i),  300'(ciss[i]), 300'(e_iss[i]));
      check($sformatf("u%0d.cnt_checked", i), 300'(cchk[i]), 300'(e_cchk[i]));
    end
  end

  logic [NI-1:0]    q_dv [$];
  logic [NI-1:0]    q_ce [$];
  logic [LOG2N-1:0] q_n1 [$];
  always @(negedge clk) begin
    q_dv.push_back({dvld[2], dvld[1], dvld[0]});
    q_ce.push_back({cen[2], cen[1], cen[0]});
    q_n1.push_back(chkv[1].n);
  end

  task automatic clear_rec();
    q_dv.delete(); q_ce.delete(); q_n1.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int unsigned k);
    vec_t v;
    v.mode   = k[0];
    v.format = k[2:1];
    v.n      = LOG2N'(k);
    v.dx     = k[3:2];
    v.dy     = k[1:0];
    v.xn     = {$urandom, $urandom};
    v.yn     = {$urandom, $urandom};
    v.xnp1   = {$urandom, $urandom};
    v.ynp1   = {$urandom, $urandom};
    return v;
  endfunction

  task automatic send(input vec_t v, input logic last, input logic vld = 1'b1, input logic st = 1'b0);
    vin = v; vec_vld = vld; vec_last = last; start = st;
    tick();
    vec_vld = 1'b0; vec_last = 1'b0; start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_all_done(input string tag);
    int k = 0;
    while (!(dne[0] && dne[1] && dne[2]) && k < 60) begin
      tick();
      k++;
    end
    check({tag, ".done_in_time"}, 300'(dne[0] & dne[1] & dne[2]), 300'(1));
  endtask

  function automatic int first_idx(input int inst, input logic use_ce);
    int sz = use_ce ? q_ce.size() : q_dv.size();
    for (int j = 0; j < sz; j++) begin
      if (use_ce ? q_ce[j][inst] : q_dv[j][inst]) return j;
    end
    return -1000;
  endfunction

  function automatic logic bit_at(input int inst, input logic use_ce, input int idx);
    if (idx < 0) return 1'b0;
    if (use_ce) return (idx < q_ce.size()) ? q_ce[idx][inst] : 1'b0;
    return (idx < q_dv.size()) ? q_dv[idx][inst] : 1'b0;
  endfunction

  initial begin
    vec_t v;
    logic [5:0] pat;
    int f, g, run, cnt;

    arst = 1'b0; srst = 1'b0; start = 1'b0; vec_vld = 1'b0; vec_last = 1'b0; vin = '0;
    tick(); tick();
    check("reset.busy_done_rdy", 300'({bsy[0], dne[0], vrdy[0]}), 300'(0));
    check("reset.cnts", 300'({ciss[0], cchk[0]}), 300'(0));
    arst = 1'b1;
    tick();

    // Single vector, LAT=1 instance u0
    pulse_start();
    v = mk(1); v.xn = 64'd5; v.xnp1 = 64'd10;
    send(v, 1'b1);
    check("single.dut_vld", 300'(dvld[0]), 300'(1));
    check("single.dut_X_n", 300'(dutv[0].xn), 300'(5));
    tick();
    check("single.chk_enable", 300'(cen[0]), 300'(1));
    check("single.chk_X_np1", 300'(chkv[0].xnp1), 300'(10));
    tick();
    check("single.done", 300'(dne[0]), 300'(1));
    check("single.cnts", 300'({ciss[0], cchk[0]}), 300'({16'd1, 16'd1}));
    wait_all_done("single");

    // Streaming 16 back-to-back, LAT=4 instance u1
    clear_rec();
    pulse_start();
    for (int k = 0; k < 16; k++) send(mk(k), k == 15);
    wait_all_done("stream");
    f = first_idx(1, 1'b0);
    g = first_idx(1, 1'b1);
    check("stream.chk_offset", 300'(g - f), 300'(4));
    run = 0;
    while (bit_at(1, 1'b1, g + run)) run++;
    check("stream.chk_run_len", 300'(run), 300'(16));
    for (int k = 0; k < 16; k++)
      check($sformatf("stream.chk_n[%0d]", k),
            300'((g + k >= 0 && g + k < q_n1.size()) ? q_n1[g + k] : 6'h3f), 300'(k));
    check("stream.u1_cnts", 300'({ciss[1], cchk[1]}), 300'({16'd16, 16'd16}));

    // Bubbles 1,0,1,1,0,1 on LAT=3 instance u2
    clear_rec();
    pat = 6'b101101;
    pulse_start();
    for (int k = 0; k < 6; k++) send(mk(k + 40), k == 5, pat[5-k]);
    wait_all_done("bubble");
    f = first_idx(2, 1'b0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("bubble.dut_vld[%0d]", k), 300'(bit_at(2, 1'b0, f + k)), 300'(pat[5-k]));
      check($sformatf("bubble.chk_en[%0d]", k), 300'(bit_at(2, 1'b1, f + 3 + k)), 300'(pat[5-k]));
    end
    check("bubble.cnt_checked", 300'({cchk[0], cchk[2]}), 300'({16'd4, 16'd4}));

    // start ignored in RUN and DRAIN, honoured in DONE
    pulse_start();
    send(mk(1), 1'b0);
    send(mk(2), 1'b0, 1'b1, 1'b1);
    send(mk(3), 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check("start_ign.busy", 300'({bsy[0], bsy[1], bsy[2]}), 300'(3'b111));
    check("start_ign.cnt_issued", 300'({ciss[0], ciss[1], ciss[2]}), 300'({16'd3, 16'd3, 16'd3}));
    wait_all_done("start_ign");
    check("start_ign.cnt_checked", 300'({cchk[0], cchk[1], cchk[2]}), 300'({16'd3, 16'd3, 16'd3}));
    pulse_start();
    check("start_done.cnts", 300'({ciss[0], cchk[0], ciss[2], cchk[2]}), 300'(0));
    check("start_done.rdy", 300'({vrdy[0], vrdy[1], vrdy[2]}), 300'(3'b111));
    send(mk(7), 1'b1);
    wait_all_done("start_done");

    // Saturation: 20 vectors on CW=4 instance u2
    pulse_start();
    for (int k = 0; k < 20; k++) send(mk(k), k == 19);
    wait_all_done("sat");
    check("sat.u2_cnts", 300'({ciss[2], cchk[2]}), 300'({16'd15, 16'd15}));
    check("sat.u0_cnts", 300'({ciss[0], cchk[0]}), 300'({16'd20, 16'd20}));

    // Synchronous reset with vectors in flight
    pulse_start();
    send(mk(11), 1'b0);
    send(mk(12), 1'b0);
    srst = 1'b1; tick(); srst = 1'b0;
    check("srst.state", 300'({bsy[0], bsy[1], bsy[2], dne[1], vrdy[1]}), 300'(0));
    clear_rec();
    repeat (8) tick();
    cnt = 0;
    foreach (q_ce[j]) if (q_ce[j] != 0) cnt++;
    check("srst.no_chk_after", 300'(cnt), 300'(0));

    // Asynchronous reset mid-RUN with 3 vectors in flight (u2, LAT=3)
    pulse_start();
    send(mk(21), 1'b0);
    send(mk(22), 1'b0);
    send(mk(23), 1'b0);
    #2 arst = 1'b0;
    #1;
    check("arst.u2_outputs", 300'({vrdy[2], dvld[2], cen[2], bsy[2], dne[2], ciss[2], cchk[2], chkv[2], dutv[2]}), 300'(0));
    tick();
    arst = 1'b1;
    clear_rec();
    repeat (8) tick();
    cnt = 0;
    foreach (q_ce[j]) if (q_ce[j] != 0) cnt++;
    check("arst.no_chk_after", 300'(cnt), 300'(0));
    check("arst.idle", 300'({bsy[2], dne[2], vrdy[2]}), 300'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/bkm_data_step_driver.md
Name: bkm_data_step_driver

Overview:
Stimulus-side counterpart of the bkm_data_step checker. It accepts test vectors (step inputs plus expected X_np1/Y_np1) over a valid/ready stream, issues them to the bkm_data_step DUT one per cycle, and delays the same vector through a LAT-deep pipeline so the checker receives the tb_* fields and an enable strobe aligned exactly with the DUT result. It sits between the vector source (file reader or generator) and the DUT/checker pair, and reports run completion and vector counts.

Parameters:
W, 64, data word width of X/Y operands and results
LOG2N, 6, width of the iteration index n
LAT, 1, DUT latency in cycles from dut_vld to valid res_X_np1/res_Y_np1; legal range 1..8
CW, 16, width of the issue/check counters

Ports:
clk  in  1  clock, all logic on rising edge
arst  in  1  asynchronous reset, active-low
srst  in  1  synchronous reset, active-high, same effect as arst
start  in  1  one-cycle pulse; arms a run
vec_vld  in  1  source vector valid
vec_rdy  out  1  driver ready to accept a vector
vec_last  in  1  marks final vector of the run
vec_mode  in  1  step mode
vec_format  in  2  step format
vec_n  in  LOG2N  iteration index
vec_d_x_n  in  2  digit d_x
vec_d_y_n  in  2  digit d_y
vec_X_n  in  W  operand X_n
vec_Y_n  in  W  operand Y_n
vec_X_np1  in  W  expected X_np1
vec_Y_np1  in  W  expected Y_np1
dut_vld  out  1  DUT input valid
dut_mode, dut_format, dut_n, dut_d_x_n, dut_d_y_n, dut_X_n, dut_Y_n  out  1/2/LOG2N/2/2/W/W  DUT inputs
chk_enable  out  1  checker enable, aligned with DUT result
chk_mode, chk_format, chk_n, chk_d_x_n, chk_d_y_n, chk_X_n, chk_Y_n, chk_X_np1, chk_Y_np1  out  matching widths  checker tb_* inputs
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE
cnt_issued  out  CW  vectors issued this run
cnt_checked  out  CW  chk_enable strobes this run

Behaviour:
- Reset (arst low asynchronously, or srst high at clock edge): state IDLE; every output 0; delay line valid bits cleared; in-flight vectors discarded, no chk_enable produced for them.
- FSM: IDLE --start--> RUN; RUN --accept with vec_last--> DRAIN; DRAIN --delay line empty--> DONE; DONE --start--> RUN. start ignored in RUN/DRAIN.
- vec_rdy = 1 only in RUN (combinational from state). Accept = vec_vld & vec_rdy. Earliest accept: the cycle after start.
- On accept, next edge: dut_* <= vec_* fields, dut_vld <= 1, delay stage 0 <= {all vec fields incl. expected, valid=1}. No accept: dut_vld <= 0, dut_* hold, stage 0 valid <= 0.
- Delay line: LAT stages, shifts every cycle unconditionally (no backpressure). chk_* = stage LAT-1 contents; chk_enable = stage LAT-1 valid. Result: chk_enable high exactly LAT cycles after the dut_vld of the same vector; chk_* hold last value when invalid.
- DRAIN: vec_rdy = 0; transition to DONE on the edge where all stage valid bits and dut_vld are 0 (last chk_enable already presented).
- Counters: cnt_issued +1 per accept, cnt_checked +1 per chk_enable; both saturate at 2^CW-1; both cleared on start from IDLE/DONE. In DONE, cnt_issued == cnt_checked.
- Back-to-back accepts sustain 1 vector/cycle; bubbles from vec_vld low propagate as chk_enable low.
- vec_last accepted on the first vector: run of length 1, legal.

Test Plan:
- Reset: arst low mid-RUN with 3 vectors in flight (LAT=3) -> all outputs 0 immediately, no chk_enable after release, state IDLE.
- Single vector, LAT=1: start, vec with vec_last, X_n=5, X_np1=10 -> dut_vld 1 cycle after accept, chk_enable with chk_X_np1=10 1 cycle later, done next, cnt_issued=cnt_checked=1.
- Streaming, LAT=4: 16 back-to-back vectors, n=0..15 -> chk_enable high 16 consecutive cycles starting 4 cycles after first dut_vld, chk_n sequence 0..15.
- Bubbles: vec_vld pattern 1,0,1,1,0,1 -> identical chk_enable pattern delayed LAT cycles, cnt_checked=4.
- start ignored: start pulsed in RUN and DRAIN -> counters not cleared, FSM unaffected; start in DONE -> counters 0, RUN.
- Saturation, CW=4: 20 vectors -> cnt_issued and cnt_checked stick at 15, done asserted normally.
